// File: rtl/leitor_matricula.sv
// leitor_matricula
// Assembles a 24-bit licence plate from three serial bytes (MSB byte first),
// looks it up in a programmable table of authorised plates (one entry per
// cycle), and emits a one-cycle MatrVal or MatrInval pulse. Also provides the
// free-running conta_ciclos counter used by the barrier block.
// Optional feature: define LEITOR_ANTIREPETICAO_EN to reject a plate that is
// matched again within REPEAT_CICLOS cycles of its last MatrVal.
module leitor_matricula #(
    parameter int N_ENTRADAS    = 8,
    parameter int TIMEOUT       = 20,
    parameter int REPEAT_CICLOS = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    byte_in,
    input  logic                          byte_val,
    input  logic                          prog_we,
    input  logic [$clog2(N_ENTRADAS)-1:0] prog_addr,
    input  logic [24:0]                   prog_data,
    output logic [6:0]                    conta_ciclos,
    output logic [23:0]                   Matricula,
    output logic                          MatrVal,
    output logic                          MatrInval,
    output logic                          erro_timeout,
    output logic                          ocupado
);

    localparam int              AW       = $clog2(N_ENTRADAS);
    localparam int              GW       = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0]   LAST_IDX = AW'(N_ENTRADAS - 1);
    localparam logic [AW:0]     N_LIM    = (AW + 1)'(N_ENTRADAS);
    localparam logic [GW-1:0]   GAP_LIM  = GW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RX1    = 3'd1,
        ST_RX2    = 3'd2,
        ST_SCAN   = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    state_t        state_r, state_next_s;
    logic [AW-1:0] idx_r, idx_next_s;
    logic [GW-1:0] gap_r, gap_next_s;
    logic [23:0]   matricula_r, mat_next_s;
    logic [6:0]    conta_r;
    logic          val_r, val_next_s;
    logic          inval_r, inval_next_s;
    logic          to_r, to_next_s;
    logic          ocup_r, ocup_next_s;

    logic          tbl_v_r [N_ENTRADAS];
    logic [23:0]   tbl_p_r [N_ENTRADAS];

    logic          match_s;
    logic          blocked_s;

    // Entry under inspection this cycle holds the assembled plate
    assign match_s = tbl_v_r[idx_r] && (tbl_p_r[idx_r] == matricula_r);

`ifdef LEITOR_ANTIREPETICAO_EN
    localparam int            RW      = $clog2(REPEAT_CICLOS + 1);
    localparam logic [RW-1:0] REP_LIM = RW'(REPEAT_CICLOS);

    logic [23:0]   rep_plate_r;
    logic [RW-1:0] rep_cnt_r;

    assign blocked_s = (rep_plate_r == matricula_r) && (rep_cnt_r < REP_LIM);

    // Remember the last authorised plate and how long ago it was accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_plate_r <= 24'h000000;
            rep_cnt_r   <= '0;
        end else if ((state_r == ST_SCAN) && match_s && !blocked_s) begin
            rep_plate_r <= matricula_r;
            rep_cnt_r   <= '0;
        end else if (rep_cnt_r < REP_LIM) begin
            rep_cnt_r   <= rep_cnt_r + RW'(1);
        end else begin
            rep_cnt_r   <= rep_cnt_r;
        end
    end
`else
    logic [31:0] unused_rep_s;
    assign unused_rep_s = 32'(REPEAT_CICLOS);
    assign blocked_s    = 1'b0;
`endif

    // Next-state, byte assembly, gap timer and result pulse decisions
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        gap_next_s   = gap_r;
        mat_next_s   = matricula_r;
        val_next_s   = 1'b0;
        inval_next_s = 1'b0;
        to_next_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (byte_val) begin
                    mat_next_s[23:16] = byte_in;
                    gap_next_s        = '0;
                    state_next_s      = ST_RX1;
                end else begin
                    state_next_s      = ST_IDLE;
                end
            end
            ST_RX1: begin
                if (byte_val) begin
                    mat_next_s[15:8] = byte_in;
                    gap_next_s       = '0;
                    state_next_s     = ST_RX2;
                end else if (gap_r == GAP_LIM) begin
                    to_next_s        = 1'b1;
                    gap_next_s       = '0;
                    state_next_s     = ST_IDLE;
                end else begin
                    gap_next_s       = gap_r + GW'(1);
                end
            end
            ST_RX2: begin
                if (byte_val) begin
                    mat_next_s[7:0] = byte_in;
                    gap_next_s      = '0;
                    idx_next_s      = '0;
                    state_next_s    = ST_SCAN;
                end else if (gap_r == GAP_LIM) begin
                    to_next_s       = 1'b1;
                    gap_next_s      = '0;
                    state_next_s    = ST_IDLE;
                end else begin
                    gap_next_s      = gap_r + GW'(1);
                end
            end
            ST_SCAN: begin
                if (match_s) begin
                    val_next_s   = !blocked_s;
                    inval_next_s = blocked_s;
                    state_next_s = ST_RESULT;
                end else if (idx_r == LAST_IDX) begin
                    inval_next_s = 1'b1;
                    state_next_s = ST_RESULT;
                end else begin
                    idx_next_s   = idx_r + AW'(1);
                end
            end
            ST_RESULT: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        ocup_next_s = (state_next_s == ST_SCAN) || (state_next_s == ST_RESULT);
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            gap_r       <= '0;
            matricula_r <= 24'h000000;
            val_r       <= 1'b0;
            inval_r     <= 1'b0;
            to_r        <= 1'b0;
            ocup_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            idx_r       <= idx_next_s;
            gap_r       <= gap_next_s;
            matricula_r <= mat_next_s;
            val_r       <= val_next_s;
            inval_r     <= inval_next_s;
            to_r        <= to_next_s;
            ocup_r      <= ocup_next_s;
        end
    end

    // Free-running cycle counter, wraps 127 -> 0
    always_ff @(posedge clk) begin
        if (reset) begin
            conta_r <= 7'd0;
        end else begin
            conta_r <= conta_r + 7'd1;
        end
    end

    // Authorised-plate table; out-of-range addresses are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_ENTRADAS; i++) begin
                tbl_v_r[i] <= 1'b0;
                tbl_p_r[i] <= 24'h000000;
            end
        end else if (prog_we && ({1'b0, prog_addr} < N_LIM)) begin
            tbl_v_r[prog_addr] <= prog_data[24];
            tbl_p_r[prog_addr] <= prog_data[23:0];
        end else begin
            for (int i = 0; i < N_ENTRADAS; i++) begin
                tbl_v_r[i] <= tbl_v_r[i];
                tbl_p_r[i] <= tbl_p_r[i];
            end
        end
    end

    assign conta_ciclos = conta_r;
    assign Matricula    = matricula_r;
    assign MatrVal      = val_r;
    assign MatrInval    = inval_r;
    assign erro_timeout = to_r;
    assign ocupado      = ocup_r;

endmodule

// File: tb/tb_leitor_matricula.sv
// Self-checking bench for leitor_matricula. A transaction-level reference
// model (byte count, gap count, busy-cycle countdown computed from the table
// lookup latency) predicts every output after each clock edge.
module tb_leitor_matricula;

    localparam int N   = 8;
    localparam int TO  = 20;
    localparam int REP = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_val = 1'b0;
    logic        prog_we = 1'b0;
    logic [2:0]  prog_addr = 3'd0;
    logic [24:0] prog_data = 25'd0;
    logic [6:0]  conta_ciclos;
    logic [23:0] Matricula;
    logic        MatrVal, MatrInval, erro_timeout, ocupado;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    leitor_matricula #(.N_ENTRADAS(N), .TIMEOUT(TO), .REPEAT_CICLOS(REP)) dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_val(byte_val),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .conta_ciclos(conta_ciclos), .Matricula(Matricula), .MatrVal(MatrVal),
        .MatrInval(MatrInval), .erro_timeout(erro_timeout), .ocupado(ocupado)
    );

    // ---------------- reference model ----------------
    int          m_cnt = 0;
    logic [23:0] m_plate = 24'h0;
    int          m_nb = 0;
    int          m_gap = 0;
    int          m_busy = 0;
    bit          m_ok = 1'b0;
    bit          m_tv [N];
    logic [23:0] m_tp [N];
    bit          e_val = 1'b0, e_inval = 1'b0, e_to = 1'b0;
`ifdef LEITOR_ANTIREPETICAO_EN
    logic [23:0] m_last = 24'h0;
    int          m_rep = 0;
`endif

    task automatic model_edge();
        int first;
        bit ok_now;
        if (reset) begin
            m_cnt = 0; m_plate = 24'h0; m_nb = 0; m_gap = 0; m_busy = 0;
            e_val = 1'b0; e_inval = 1'b0; e_to = 1'b0;
            for (int i = 0; i < N; i++) m_tv[i] = 1'b0;
`ifdef LEITOR_ANTIREPETICAO_EN
            m_last = 24'h0; m_rep = 0;
`endif
        end else begin
            m_cnt = (m_cnt + 1) % 128;
            e_val = 1'b0; e_inval = 1'b0; e_to = 1'b0;
            if (prog_we && int'(prog_addr) < N) begin
                m_tv[prog_addr] = prog_data[24];
                m_tp[prog_addr] = prog_data[23:0];
            end
            if (m_busy > 0) begin
                m_busy--;
            end else if (byte_val) begin
                m_plate[23 - 8*m_nb -: 8] = byte_in;
                m_nb++;
                m_gap = 0;
                if (m_nb == 3) begin
                    m_nb = 0;
                    first = -1;
                    for (int i = 0; i < N; i++)
                        if (first < 0 && m_tv[i] && m_tp[i] == m_plate) first = i;
                    m_ok   = (first >= 0);
                    m_busy = m_ok ? first + 2 : N + 1;
                end
            end else if (m_nb > 0) begin
                m_gap++;
                if (m_gap == TO) begin
                    e_to = 1'b1;
                    m_nb = 0;
                end
            end
            ok_now = m_ok;
`ifdef LEITOR_ANTIREPETICAO_EN
            if (m_busy == 1 && m_ok && m_plate == m_last && m_rep < REP) ok_now = 1'b0;
            if (m_busy == 1 && ok_now) begin
                m_last = m_plate; m_rep = 0;
            end else if (m_rep < REP) begin
                m_rep++;
            end
`endif
            e_val   = (m_busy == 1) && ok_now;
            e_inval = (m_busy == 1) && !ok_now;
        end
    endtask

    function automatic logic [34:0] exp_vec();
        return {7'(m_cnt), m_plate, e_val, e_inval, e_to, (m_busy > 0)};
    endfunction

    function automatic logic [34:0] obs_vec();
        return {conta_ciclos, Matricula, MatrVal, MatrInval, erro_timeout, ocupado};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic program_entry(input int a, input logic [24:0] d);
        prog_we = 1'b1; prog_addr = a[2:0]; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (obs_vec() !== 35'd0) begin
            errors++; $display("FAIL reset_state got %h exp %h", obs_vec(), 35'd0);
        end
        reset = 1'b0;
        for (int k = 1; k <= 130; k++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL reset_idle k=%0d got %h exp %h", k, obs_vec(), exp_vec());
            end
            if (k == 127 || k == 128) begin
                checks++;
                if (conta_ciclos !== ((k == 127) ? 7'd127 : 7'd0)) begin
                    errors++; $display("FAIL conta_wrap k=%0d got %0d", k, conta_ciclos);
                end
            end
        end
    endtask

    task automatic test_match();
        logic [23:0] pl = 24'hA1B2C3;
        int vcnt = 0, vc = -1, icnt = 0;
        program_entry(3, {1'b1, pl});
        for (int c = 0; c < 12; c++) begin
            byte_val = (c < 3);
            byte_in  = (c < 3) ? pl[23 - 8*c -: 8] : 8'h00;
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL match c=%0d got %h exp %h", c, obs_vec(), exp_vec());
            end
            if (MatrVal)   begin vcnt++; vc = c; end
            if (MatrInval) icnt++;
        end
        byte_val = 1'b0;
        checks++;
        if (vcnt != 1 || vc != 6 || icnt != 0 || Matricula !== pl) begin
            errors++; $display("FAIL match_latency got vcnt=%0d vc=%0d icnt=%0d mat=%h exp 1 6 0 %h", vcnt, vc, icnt, Matricula, pl);
        end
    endtask

    task automatic test_nomatch();
        logic [23:0] pl = 24'h123456;
        int icnt = 0, ic = -1, vcnt = 0, ocnt = 0;
        for (int c = 0; c < 14; c++) begin
            byte_val = (c < 3) || (c == 6);
            byte_in  = (c < 3) ? pl[23 - 8*c -: 8] : 8'hA1;
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL nomatch c=%0d got %h exp %h", c, obs_vec(), exp_vec());
            end
            if (MatrInval) begin icnt++; ic = c; end
            if (MatrVal)   vcnt++;
            if (ocupado)   ocnt++;
        end
        byte_val = 1'b0;
        checks++;
        if (icnt != 1 || ic != 10 || vcnt != 0 || ocnt != 9 || Matricula !== pl) begin
            errors++; $display("FAIL nomatch_timing got icnt=%0d ic=%0d vcnt=%0d ocnt=%0d mat=%h exp 1 10 0 9 %h", icnt, ic, vcnt, ocnt, Matricula, pl);
        end
    endtask

    task automatic test_timeout();
        logic [23:0] pl = 24'hA1B2C3;
        int tcnt = 0, tc = -1, rcnt = 0, rc = -1;
        for (int c = 0; c < 25; c++) begin
            byte_val = (c == 0); byte_in = 8'hA1;
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL timeout c=%0d got %h exp %h", c, obs_vec(), exp_vec());
            end
            if (erro_timeout) begin tcnt++; tc = c; end
        end
        checks++;
        if (tcnt != 1 || tc != 20) begin
            errors++; $display("FAIL timeout_pulse got tcnt=%0d tc=%0d exp 1 20", tcnt, tc);
        end
        for (int c = 0; c < 12; c++) begin
            byte_val = (c < 3);
            byte_in  = (c < 3) ? pl[23 - 8*c -: 8] : 8'h00;
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL after_timeout c=%0d got %h exp %h", c, obs_vec(), exp_vec());
            end
            if (MatrVal || MatrInval) begin rcnt++; rc = c; end
        end
        checks++;
        if (rcnt != 1 || rc != 6) begin
            errors++; $display("FAIL after_timeout_result got rcnt=%0d rc=%0d exp 1 6", rcnt, rc);
        end
        tcnt = 0; rcnt = 0; rc = -1;
        for (int c = 0; c < 32; c++) begin
            byte_val = (c == 0) || (c == 20) || (c == 21);
            byte_in  = (c == 0) ? 8'hA1 : (c == 20) ? 8'hB2 : 8'hC3;
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL gap_exact c=%0d got %h exp %h", c, obs_vec(), exp_vec());
            end
            if (erro_timeout) tcnt++;
            if (MatrVal || MatrInval) begin rcnt++; rc = c; end
        end
        byte_val = 1'b0;
        checks++;
        if (tcnt != 0 || rcnt != 1 || rc != 25) begin
            errors++; $display("FAIL gap_exact_result got tcnt=%0d rcnt=%0d rc=%0d exp 0 1 25", tcnt, rcnt, rc);
        end
    endtask

    task automatic test_reset_scan();
        logic [23:0] pl = 24'hA1B2C3;
        int pcnt = 0, vcnt = 0, icnt = 0, ic = -1;
        for (int c = 0; c < 10; c++) begin
            byte_val = (c < 3);
            byte_in  = (c < 3) ? pl[23 - 8*c -: 8] : 8'h00;
            reset    = (c == 4);
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL reset_scan c=%0d got %h exp %h", c, obs_vec(), exp_vec());
            end
            if (c == 4) begin
                checks++;
                if (obs_vec() !== 35'd0) begin
                    errors++; $display("FAIL reset_scan_zero got %h exp %h", obs_vec(), 35'd0);
                end
            end
            if (MatrVal || MatrInval) pcnt++;
        end
        reset = 1'b0;
        checks++;
        if (pcnt != 0) begin
            errors++; $display("FAIL reset_scan_pulse got %0d exp 0", pcnt);
        end
        for (int c = 0; c < 14; c++) begin
            byte_val = (c < 3);
            byte_in  = (c < 3) ? pl[23 - 8*c -: 8] : 8'h00;
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL table_cleared c=%0d got %h exp %h", c, obs_vec(), exp_vec());
            end
            if (MatrVal)   vcnt++;
            if (MatrInval) begin icnt++; ic = c; end
        end
        byte_val = 1'b0;
        checks++;
        if (vcnt != 0 || icnt != 1 || ic != 10) begin
            errors++; $display("FAIL table_cleared_result got vcnt=%0d icnt=%0d ic=%0d exp 0 1 10", vcnt, icnt, ic);
        end
    endtask

    task automatic test_antirepeat();
        logic [23:0] pl = 24'hA1B2C3;
        int vcnt, icnt;
        bit exp_block;
`ifdef LEITOR_ANTIREPETICAO_EN
        exp_block = 1'b1;
`else
        exp_block = 1'b0;
`endif
        reset = 1'b1; tick(); reset = 1'b0;
        program_entry(3, {1'b1, pl});
        for (int pass = 0; pass < 3; pass++) begin
            vcnt = 0; icnt = 0;
            for (int c = 0; c < ((pass == 2) ? 80 : 16); c++) begin
                byte_val = (c < 3);
                byte_in  = (c < 3) ? pl[23 - 8*c -: 8] : 8'h00;
                tick();
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++; $display("FAIL antirepeat p=%0d c=%0d got %h exp %h", pass, c, obs_vec(), exp_vec());
                end
                if (MatrVal)   vcnt++;
                if (MatrInval) icnt++;
            end
            byte_val = 1'b0;
            checks++;
            if ((pass == 1 && exp_block) ? (vcnt != 0 || icnt != 1) : (vcnt != 1 || icnt != 0)) begin
                errors++; $display("FAIL antirepeat_result p=%0d got val=%0d inval=%0d blocking=%0d", pass, vcnt, icnt, exp_block);
            end
            if (pass == 1) repeat (70) begin
                tick();
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++; $display("FAIL antirepeat_idle got %h exp %h", obs_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_random();
        logic [23:0] pool [4];
        int idle_run = 0;
        int r;
        pool[0] = 24'hA1B2C3; pool[1] = 24'h123456; pool[2] = 24'hA1B256; pool[3] = 24'h12B2C3;
        reset = 1'b1; tick(); reset = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (m_busy == 0 && $urandom_range(0, 7) == 0) begin
                prog_we   = 1'b1;
                prog_addr = 3'($urandom_range(0, N - 1));
                prog_data = {1'($urandom_range(0, 3) != 0), pool[$urandom_range(0, 3)]};
            end else begin
                prog_we = 1'b0;
            end
            r = $urandom_range(0, 99);
            if (idle_run > 0) begin
                idle_run--;
                byte_val = 1'b0;
            end else if (r == 99) begin
                idle_run = $urandom_range(17, 23);
                byte_val = 1'b0;
            end else begin
                byte_val = (r < 45);
            end
            byte_in = pool[$urandom_range(0, 3)][23 - 8*m_nb -: 8];
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random c=%0d got %h exp %h", c, obs_vec(), exp_vec());
            end
        end
        prog_we = 1'b0; byte_val = 1'b0;
    endtask

    initial begin
        test_reset();
        test_match();
        test_nomatch();
        test_timeout();
        test_reset_scan();
        test_antirepeat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/leitor_matricula.md
Name: leitor_matricula

Overview:
- Producer side of the barrier control interface. Receives a licence plate as three serial bytes from the plate-reader front end and assembles it into a 24-bit Matricula.
- Checks the plate against a programmable table of authorised plates. Emits a one-cycle MatrVal pulse (or MatrInval) together with the free-running 7-bit conta_ciclos that the barrier block uses to time closing.

Parameters:
- N_ENTRADAS, 8, number of authorised-plate table entries (2..16).
- TIMEOUT, 20, maximum idle cycles allowed between bytes of one plate.
- REPEAT_CICLOS, 64, anti-repeat window in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- byte_in  in  8  plate byte, MSB byte first
- byte_val  in  1  byte_in valid this cycle
- prog_we  in  1  table write strobe
- prog_addr  in  $clog2(N_ENTRADAS)  table entry index
- prog_data  in  25  bit 24 = entry valid, bits 23:0 = plate
- conta_ciclos  out  7  free-running cycle counter
- Matricula  out  24  last assembled plate
- MatrVal  out  1  one-cycle pulse, plate authorised
- MatrInval  out  1  one-cycle pulse, plate rejected
- erro_timeout  out  1  one-cycle pulse, byte gap exceeded TIMEOUT
- ocupado  out  1  high while scanning; bytes are ignored

Behaviour:
- Reset (synchronous, active-high):
  - conta_ciclos=0, Matricula=0, MatrVal=0, MatrInval=0, erro_timeout=0, ocupado=0.
  - FSM goes to IDLE; all table valid bits cleared.
  - Reset overrides any operation in progress; no pulse is emitted for a partial plate.
- conta_ciclos: increments every cycle and wraps 127->0. Never stalls.
- FSM states:
  - IDLE: byte_val loads Matricula[23:16] and moves to RX1.
  - RX1: byte_val loads [15:8] and moves to RX2.
  - RX2: byte_val loads [7:0] and moves to SCAN.
  - SCAN: compares table entry idx = 0..N_ENTRADAS-1, one entry per cycle.
    - First valid entry equal to Matricula -> RESULT with ok=1.
    - Entry N_ENTRADAS-1 checked with no match -> RESULT with ok=0.
  - RESULT: one cycle; drives MatrVal=ok, MatrInval=!ok; returns to IDLE.
- Latency: last byte sampled at edge t; entry i compared in cycle t+1+i.
  - Match at entry i -> MatrVal high in cycle t+2+i.
  - No match -> MatrInval high in cycle t+1+N_ENTRADAS.
- Pulses: MatrVal and MatrInval are mutually exclusive, each exactly one cycle. Matricula is stable from SCAN entry until the next IDLE byte.
- ocupado is 1 in SCAN and RESULT. byte_val in those states is dropped, with no effect.
- Timeout:
  - In RX1/RX2, a gap counter resets on each accepted byte.
  - When the gap reaches TIMEOUT cycles without byte_val, pulse erro_timeout for one cycle and return to IDLE. Matricula keeps its partial contents.
  - byte_val arriving in the same cycle the gap reaches TIMEOUT is accepted as the next byte, and no timeout fires.
- Table writes:
  - prog_we writes prog_data to prog_addr at the edge, in any state.
  - A SCAN comparison in the same cycle uses the pre-edge entry contents.
  - prog_addr >= N_ENTRADAS is ignored.
- Duplicate entries: the lowest index wins; the result is identical either way.

Optional Feature:
- Macro: LEITOR_ANTIREPETICAO_EN
- Defined:
  - On each MatrVal, store the plate and start a repeat counter.
  - If the same plate is matched again while the counter < REPEAT_CICLOS, RESULT emits MatrInval instead of MatrVal. Latency is unchanged.
  - The counter saturates at REPEAT_CICLOS. Reset clears both the stored plate and the counter.
- Undefined: no storage or counter is synthesised; every table match yields MatrVal.

Test Plan:
- Reset then idle 130 cycles -> conta_ciclos wraps 127->0; all pulses 0; Matricula=0.
- Program entry 3 = {1,24'hA1B2C3}; send A1,B2,C3 back-to-back, last byte at edge t -> MatrVal=1 only in cycle t+5; Matricula=24'hA1B2C3; MatrInval never high.
- Send 12,34,56 with no match, N_ENTRADAS=8 -> MatrInval one cycle at t+9; ocupado high t+1..t+9; a byte_val injected at t+4 is ignored.
- Send A1, then a 20-cycle gap -> erro_timeout pulse; FSM in IDLE. Next A1,B2,C3 is accepted normally. Repeat with the byte at gap=20 exactly -> no timeout.
- Assert reset during SCAN -> no MatrVal/MatrInval; all outputs 0 next cycle; table cleared, so the same plate afterwards gives MatrInval.
- With LEITOR_ANTIREPETICAO_EN: accept A1B2C3, resend 10 cycles later -> MatrInval. Resend after 70 cycles -> MatrVal. Without the macro, both resends -> MatrVal.
